// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, flush, saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and a registered ready_o.
module pipe_stage_reg #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              in_xfer;
    logic              out_xfer;

    assign out_xfer = m_valid_q & ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;

    // ready_o comes straight from a flop so no path runs back from ready_i
    assign ready_o = ~s_valid_q;
    assign in_xfer = valid_i & ready_o;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            // S is only occupied while M is valid, so ready_i alone drains M
            if (ready_i) begin
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!m_valid_q || ready_i) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = ctrl_i;
                m_data_d  = data_i;
            end else begin
                s_valid_d = 1'b1;
                s_ctrl_d  = ctrl_i;
                s_data_d  = data_i;
            end
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end
`else
    assign ready_o = ready_i | ~m_valid_q;
    assign in_xfer = valid_i & ready_o;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
        end else if (in_xfer) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = ctrl_i;
            m_data_d  = data_i;
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !ready_i && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_valid_q   <= 1'b0;
            m_ctrl_q    <= '0;
            m_data_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_ctrl_q    <= m_ctrl_d;
            m_data_q    <= m_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o     = m_valid_q;
    assign ctrl_o      = m_ctrl_q & {CTRL_W{m_valid_q}};
    assign data_o      = m_data_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
